// File: rtl/parity_tx_mos.sv
`timescale 1ns/1ps
// Serial byte transmitter: start, 8 data bits LSB first, optional odd-parity bit (PARITY_TX_PARITY_EN), stop.
// tx_out goes low the cycle after a valid/ready handshake; ready_out is high only in IDLE, and valid_in is ignored while a frame is in flight.

`ifdef PARITY_TX_PARITY_EN
// Static CMOS inverter.
module cmos_not (
  input  wire a,
  output wire y
);
  supply1 vdd;
  supply0 gnd;
  pmos p0 (y, vdd, a);
  nmos n0 (y, gnd, a);
endmodule

// NAND stage followed by an inverter.
module cmos_and2 (
  input  wire a,
  input  wire b,
  output wire y
);
  supply1 vdd;
  supply0 gnd;
  wire nd;
  wire mid;
  pmos p0 (nd, vdd, a);
  pmos p1 (nd, vdd, b);
  nmos n0 (nd, mid, a);
  nmos n1 (mid, gnd, b);
  cmos_not u_inv (.a(nd), .y(y));
endmodule

// NOR stage followed by an inverter.
module cmos_or2 (
  input  wire a,
  input  wire b,
  output wire y
);
  supply1 vdd;
  supply0 gnd;
  wire nr;
  wire mid;
  pmos p0 (mid, vdd, a);
  pmos p1 (nr, mid, b);
  nmos n0 (nr, gnd, a);
  nmos n1 (nr, gnd, b);
  cmos_not u_inv (.a(nr), .y(y));
endmodule

// y = (a & b) | (~a & ~b).
module cmos_xnor2 (
  input  wire a,
  input  wire b,
  output wire y
);
  wire na;
  wire nb;
  wire both_hi;
  wire both_lo;
  cmos_not  u_na (.a(a), .y(na));
  cmos_not  u_nb (.a(b), .y(nb));
  cmos_and2 u_hi (.a(a), .b(b), .y(both_hi));
  cmos_and2 u_lo (.a(na), .b(nb), .y(both_lo));
  cmos_or2  u_or (.a(both_hi), .b(both_lo), .y(y));
endmodule

// XNOR tree: every level stays inverted, so the root equals ~^d.
module parity_xnor8 (
  input  wire [7:0] d,
  output wire       y
);
  wire [3:0] l1;
  wire [1:0] l2;
  cmos_xnor2 u_a0 (.a(d[0]),  .b(d[1]),  .y(l1[0]));
  cmos_xnor2 u_a1 (.a(d[2]),  .b(d[3]),  .y(l1[1]));
  cmos_xnor2 u_a2 (.a(d[4]),  .b(d[5]),  .y(l1[2]));
  cmos_xnor2 u_a3 (.a(d[6]),  .b(d[7]),  .y(l1[3]));
  cmos_xnor2 u_b0 (.a(l1[0]), .b(l1[1]), .y(l2[0]));
  cmos_xnor2 u_b1 (.a(l1[2]), .b(l1[3]), .y(l2[1]));
  cmos_xnor2 u_c0 (.a(l2[0]), .b(l2[1]), .y(y));
endmodule
`endif

// Frame sequencer; tx_out and busy are registered.
module parity_tx_mos #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx_out,
  output logic       busy
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
`ifdef PARITY_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
`endif
  localparam logic [2:0] S_STOP   = 3'd4;
  localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;
  logic       bit_end;

  // Rotating rather than shifting keeps the parity of shift_q equal to the captured byte.
`ifdef PARITY_TX_PARITY_EN
  logic parity_bit;
  parity_xnor8 u_parity (.d(shift_q), .y(parity_bit));
`endif

  assign bit_end   = (cnt_q == LAST_CNT);
  assign ready_out = (state_q == S_IDLE);
  assign tx_out    = tx_q;
  assign busy      = busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    case (state_q)
      S_IDLE: begin
        tx_d  = 1'b1;
        cnt_d = 8'd0;
        bit_d = 3'd0;
        if (valid_in) begin
          state_d = S_START;
          shift_d = data_in;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cnt_d   = 8'd0;
          tx_d    = shift_q[0];
          shift_d = {shift_q[0], shift_q[7:1]};
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_d = 8'd0;
          if (bit_q == 3'd7) begin
`ifdef PARITY_TX_PARITY_EN
            state_d = S_PARITY;
            tx_d    = parity_bit;
`else
            state_d = S_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {shift_q[0], shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`ifdef PARITY_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          cnt_d   = 8'd0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
        bit_d   = 3'd0;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end
endmodule

// File: tb/tb_parity_tx_mos.sv
`timescale 1ns/1ps
// Bench for parity_tx_mos: three instances (4, 1 and 2 clocks per bit) checked against a queue of expected line levels.
module tb_parity_tx_mos;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] vld;
  logic [2:0] rdy;
  logic [2:0] tx;
  logic [2:0] bsy;
  logic [7:0] dat [3];
  int         errors = 0;
  int         checks = 0;
  logic       exp_q[$];

`ifdef PARITY_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  always #5 clk = ~clk;

  parity_tx_mos #(.CLKS_PER_BIT(4)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n), .data_in(dat[0]), .valid_in(vld[0]),
    .ready_out(rdy[0]), .tx_out(tx[0]), .busy(bsy[0]));
  parity_tx_mos #(.CLKS_PER_BIT(1)) u_dut_c1 (
    .clk(clk), .rst_n(rst_n), .data_in(dat[1]), .valid_in(vld[1]),
    .ready_out(rdy[1]), .tx_out(tx[1]), .busy(bsy[1]));
  parity_tx_mos #(.CLKS_PER_BIT(2)) u_dut_c2 (
    .clk(clk), .rst_n(rst_n), .data_in(dat[2]), .valid_in(vld[2]),
    .ready_out(rdy[2]), .tx_out(tx[2]), .busy(bsy[2]));

  function automatic int cpb(input int lane);
    return (lane == 0) ? 4 : (lane == 1) ? 1 : 2;
  endfunction

  // Expected line level for every cycle of one frame.
  task automatic push_frame(input int lane, input logic [7:0] b);
    logic bits[$];
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(b[k]);
`ifdef PARITY_TX_PARITY_EN
    bits.push_back(~^b);
`endif
    bits.push_back(1'b1);
    foreach (bits[k]) repeat (cpb(lane)) exp_q.push_back(bits[k]);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    vld   = 3'b111;
    dat[0] = 8'h00; dat[1] = 8'h00; dat[2] = 8'h00;
    tick;
    checks++;
    if (tx !== 3'b111 || bsy !== 3'b000 || rdy !== 3'b111) begin
      errors++;
      $display("FAIL reset_handshake: tx=%b busy=%b ready=%b expected 111/000/111", tx, bsy, rdy);
    end
    rst_n = 1'b1;
    vld   = 3'b000;
    for (int i = 0; i < 20; i++) begin
      tick;
      checks++;
      if (tx !== 3'b111) begin errors++; $display("FAIL idle_tx cycle %0d: tx=%b expected 111", i, tx); end
      checks++;
      if (bsy !== 3'b000) begin errors++; $display("FAIL idle_busy cycle %0d: busy=%b expected 000", i, bsy); end
      checks++;
      if (rdy !== 3'b111) begin errors++; $display("FAIL idle_ready cycle %0d: ready=%b expected 111", i, rdy); end
    end
  endtask

  task automatic test_frame_zero;
    int n;
    logic e;
    exp_q.delete();
    push_frame(0, 8'h00);
    n = exp_q.size();
    dat[0] = 8'h00;
    vld[0] = 1'b1;
    tick;
    vld[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (tx[0] !== e) begin errors++; $display("FAIL zero_frame bit cycle %0d: tx=%b expected %b", i, tx[0], e); end
      checks++;
      if (bsy[0] !== 1'b1 || rdy[0] !== 1'b0) begin
        errors++; $display("FAIL zero_frame status cycle %0d: busy=%b ready=%b expected 1/0", i, bsy[0], rdy[0]);
      end
      // A request while busy must be dropped, not queued.
      if (i == 6) begin vld[0] = 1'b1; dat[0] = 8'h5A; end
      if (i == 7) vld[0] = 1'b0;
      tick;
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (tx[0] !== 1'b1 || bsy[0] !== 1'b0) begin
        errors++; $display("FAIL zero_frame after cycle %0d: tx=%b busy=%b expected 1/0", i, tx[0], bsy[0]);
      end
      tick;
    end
  endtask

  task automatic test_back_to_back;
    int f;
    int n;
    logic e;
    exp_q.delete();
    push_frame(1, 8'hA5);
    exp_q.push_back(1'b1);
    push_frame(1, 8'h01);
    f = NBITS;
    n = exp_q.size();
    dat[1] = 8'hA5;
    vld[1] = 1'b1;
    tick;
    dat[1] = 8'h01;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (tx[1] !== e) begin errors++; $display("FAIL b2b bit cycle %0d: tx=%b expected %b", i, tx[1], e); end
      checks++;
      if (bsy[1] !== (i != f) || rdy[1] !== (i == f)) begin
        errors++; $display("FAIL b2b status cycle %0d: busy=%b ready=%b expected %b/%b", i, bsy[1], rdy[1], (i != f), (i == f));
      end
      if (i == f + 1) vld[1] = 1'b0;
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx[1] !== 1'b1 || bsy[1] !== 1'b0) begin
        errors++; $display("FAIL b2b after cycle %0d: tx=%b busy=%b expected 1/0", i, tx[1], bsy[1]);
      end
      tick;
    end
  endtask

  task automatic test_data_hold;
    int n;
    logic e;
    exp_q.delete();
    push_frame(0, 8'hFF);
    n = exp_q.size();
    dat[0] = 8'hFF;
    vld[0] = 1'b1;
    tick;
    vld[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (tx[0] !== e) begin errors++; $display("FAIL data_hold cycle %0d: tx=%b expected %b", i, tx[0], e); end
      if (i == 0) dat[0] = 8'h00;
      tick;
    end
  endtask

  task automatic test_reset_mid_frame;
    int n;
    logic e;
    exp_q.delete();
    push_frame(0, 8'h3C);
    dat[0] = 8'h3C;
    vld[0] = 1'b1;
    tick;
    vld[0] = 1'b0;
    // Cycle 17 sits in the middle of data bit 3 at four clocks per bit.
    for (int i = 0; i < 18; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (tx[0] !== e) begin errors++; $display("FAIL abort_pre cycle %0d: tx=%b expected %b", i, tx[0], e); end
      if (i < 17) tick;
    end
    rst_n = 1'b0;
    tick;
    checks++;
    if (tx[0] !== 1'b1 || bsy[0] !== 1'b0 || rdy[0] !== 1'b1) begin
      errors++; $display("FAIL abort_reset: tx=%b busy=%b ready=%b expected 1/0/1", tx[0], bsy[0], rdy[0]);
    end
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      tick;
      checks++;
      if (tx[0] !== 1'b1 || bsy[0] !== 1'b0) begin
        errors++; $display("FAIL abort_quiet cycle %0d: tx=%b busy=%b expected 1/0", i, tx[0], bsy[0]);
      end
    end
    push_frame(0, 8'h96);
    n = exp_q.size();
    dat[0] = 8'h96;
    vld[0] = 1'b1;
    tick;
    vld[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (tx[0] !== e) begin errors++; $display("FAIL abort_next cycle %0d: tx=%b expected %b", i, tx[0], e); end
      tick;
    end
  endtask

  task automatic test_frame_length;
    int n;
    int busy_cycles;
    logic e;
    exp_q.delete();
    push_frame(2, 8'h81);
    n = exp_q.size();
    busy_cycles = 0;
    dat[2] = 8'h81;
    vld[2] = 1'b1;
    tick;
    vld[2] = 1'b0;
    for (int i = 0; i < n + 4; i++) begin
      if (i < n) begin
        e = exp_q.pop_front();
        checks++;
        if (tx[2] !== e) begin errors++; $display("FAIL len_frame cycle %0d: tx=%b expected %b", i, tx[2], e); end
      end
      if (bsy[2] === 1'b1) busy_cycles++;
      tick;
    end
    checks++;
    if (busy_cycles != NBITS * 2) begin
      errors++; $display("FAIL len_busy: busy for %0d cycles expected %0d", busy_cycles, NBITS * 2);
    end
  endtask

  initial begin
    test_reset();
    test_frame_zero();
    test_back_to_back();
    test_data_hold();
    test_reset_mid_frame();
    test_frame_length();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/parity_tx_mos.md
PARITY_TX_MOS -- requirements
Module: parity_tx_mos

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clock cycles per serial bit; legal range 1..255.
REQ-002 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 data_in  input  8  byte to transmit; sampled only on handshake.
REQ-005 valid_in  input  1  producer offers data_in.
REQ-006 ready_out  output  1  block can accept a byte this cycle.
REQ-007 tx_out  output  1  serial line; idle level 1.
REQ-008 busy  output  1  frame in progress (any state except IDLE).

Function
REQ-009 The block SHALL transmit one frame per accepted byte: start bit (0), data bits LSB first, parity bit, stop bit (1).
REQ-010 The parity bit SHALL equal the XNOR-reduction of the captured byte: 1 when the byte has an even count of ones, giving odd total parity.
REQ-011 The parity reduction SHALL be built structurally from the team's CMOS switch-level cells (nmos/pmos not, and, or, xnor); state registers and counters may be behavioural.
REQ-012 The handshake SHALL complete on a rising edge where valid_in=1 and ready_out=1; data_in is captured into an internal shift register at that edge.
REQ-013 ready_out SHALL be 1 only in IDLE; valid_in while ready_out=0 is ignored and not queued.
REQ-014 States: IDLE -> START on handshake; START -> DATA after CLKS_PER_BIT cycles; DATA -> PARITY after 8 bits; PARITY -> STOP after CLKS_PER_BIT cycles; STOP -> IDLE after CLKS_PER_BIT cycles.
REQ-015 tx_out SHALL be 0 starting the cycle after the handshake edge; each bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-016 A full frame SHALL occupy 11*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
REQ-017 The IDLE state SHALL last at least one cycle between frames; with valid_in held high, consecutive start bits are separated by exactly 11*CLKS_PER_BIT+1 cycles.
REQ-018 Changes on data_in after the handshake SHALL NOT affect the frame in flight.
REQ-019 The bit counter SHALL be 3 bits and count 0..7; the transition from 7 ends DATA.
REQ-020 The cycle counter SHALL be wide enough for CLKS_PER_BIT-1 and reset to 0 on every bit boundary; CLKS_PER_BIT=1 SHALL produce one cycle per bit.
REQ-021 tx_out and busy SHALL be registered outputs with no combinational path from valid_in or data_in.

Reset
REQ-022 When rst_n=0 at a rising edge: state=IDLE, tx_out=1, busy=0, ready_out=1, counters=0, shift register=0, starting the following cycle.
REQ-023 Reset asserted mid-frame SHALL abort the frame; no partial remainder is sent after release.
REQ-024 A handshake in the same cycle as rst_n=0 SHALL be discarded.

Configuration
REQ-025 Macro PARITY_TX_PARITY_EN: when defined, frames include the parity bit (11 bits, PARITY state present).
REQ-026 When PARITY_TX_PARITY_EN is undefined: the PARITY state and the switch-level parity logic are omitted; DATA -> STOP directly; frame length is 10*CLKS_PER_BIT cycles; inter-frame spacing is 10*CLKS_PER_BIT+1 cycles.

Verification
REQ-027 Reset then idle for 20 cycles -> tx_out=1, busy=0, ready_out=1 throughout.
REQ-028 CLKS_PER_BIT=4, send 0x00 -> line 0,0,0,0,0,0,0,0,0, parity 1, stop 1, each held 4 cycles, 44 cycles total.
REQ-029 CLKS_PER_BIT=1, send 0xA5 then 0x01 back-to-back with valid_in held high -> bits 0,1,0,1,0,0,1,0,1,1(parity),1, then one idle cycle, then 0,1,0,0,0,0,0,0,0,0(parity),1.
REQ-030 Send 0xFF and change data_in to 0x00 one cycle after the handshake -> frame still carries 0xFF with parity 1.
REQ-031 Assert rst_n=0 during data bit 3 of a frame -> tx_out=1, busy=0 the next cycle; the next handshake produces a clean full frame.
REQ-032 Build without PARITY_TX_PARITY_EN, CLKS_PER_BIT=2, send 0x81 -> 0,1,0,0,0,0,0,0,1,1, each held 2 cycles, 20 cycles total.
